// File: rtl/resolution_overlay_pkg.sv
// -----------------------------------------------------------------------------
// resolution_overlay_pkg
// Shared definitions for the resolution text overlay:
//   RESLINE_SIZE  width of one resolution-text ROM row (pixels per line)
//   ROM_ROW_W     address width of the 16-row text ROM
//   COORD_W       width of the video timing counters
//   BIT_CNT_W     width of the emitted-bit counter in the shifter
//   SUB_CNT_W     width of the pixel-repeat sub-counter (scale up to 8x)
//   OverlayState  sequencer state encoding
//   line_offset   line distance from the window top, one bit wider than the
//                 counter so lines above the window wrap to large values
// -----------------------------------------------------------------------------
package resolution_overlay_pkg;

    localparam int RESLINE_SIZE = 136;
    localparam int ROM_ROW_W    = 4;
    localparam int COORD_W      = 12;
    localparam int BIT_CNT_W    = 8;
    localparam int SUB_CNT_W    = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ARMED = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } OverlayState;

    function automatic logic [COORD_W:0] line_offset(
        input logic [COORD_W-1:0] counter_y,
        input logic [COORD_W-1:0] y_start
    );
        return {1'b0, counter_y} - {1'b0, y_start};
    endfunction

endpackage

// File: rtl/resolution_overlay_if.sv
// -----------------------------------------------------------------------------
// resolution_overlay_if
// Bundles the timing-generator, ROM and pixel-mux signals of the overlay.
//   enable, line_start, counter_x, counter_y : from the video timing generator
//   rom_addr (out) / rom_q (in)              : resolution text ROM port
//   overlay_px, overlay_active               : to the pixel mux
//   debug_state                              : live sequencer state
// Signalling contract: there is no valid/ready pair. line_start is a one-cycle
// strobe that is always accepted; counter_y and enable only matter while it is
// high. rom_q must hold the row addressed by rom_addr one cycle after rom_addr
// changes. overlay_px is meaningful only while overlay_active is high (and is
// forced to 0 otherwise).
// master: the surrounding video pipeline; slave: the overlay sequencer.
// -----------------------------------------------------------------------------
interface resolution_overlay_if;
    import resolution_overlay_pkg::*;

    logic                    enable;
    logic                    line_start;
    logic [COORD_W-1:0]      counter_x;
    logic [COORD_W-1:0]      counter_y;
    logic [ROM_ROW_W-1:0]    rom_addr;
    logic [RESLINE_SIZE-1:0] rom_q;
    logic                    overlay_px;
    logic                    overlay_active;
    OverlayState             debug_state;

    modport master (
        output enable, line_start, counter_x, counter_y, rom_q,
        input  rom_addr, overlay_px, overlay_active, debug_state
    );

    modport slave (
        input  enable, line_start, counter_x, counter_y, rom_q,
        output rom_addr, overlay_px, overlay_active, debug_state
    );

endinterface

// File: rtl/resolution_overlay_shifter.sv
// -----------------------------------------------------------------------------
// resolution_overlay_shifter
// Holds one glyph row and walks it out MSB-first, repeating each bit
// 2^SCALE_LOG2 cycles.
//   clock, reset : pixel clock, synchronous active-high reset
//   load         : capture data, clear both counters
//   data         : ROM row to capture
//   run          : advance one pixel this cycle
//   shift_bit    : current row bit (register MSB)
//   last         : high in the cycle that advances past the final pixel
// -----------------------------------------------------------------------------
module resolution_overlay_shifter
    import resolution_overlay_pkg::*;
#(
    parameter int SCALE_LOG2 = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [RESLINE_SIZE-1:0] data,
    input  logic                    run,
    output logic                    shift_bit,
    output logic                    last
);

    localparam logic [SUB_CNT_W-1:0] SUB_LAST = SUB_CNT_W'((1 << SCALE_LOG2) - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(RESLINE_SIZE - 1);

    logic [RESLINE_SIZE-1:0] shreg;
    logic [SUB_CNT_W-1:0]    sub_cnt;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic                    sub_wrap;

    // The current bit has been shown for its full repeat count.
    assign sub_wrap = (sub_cnt == SUB_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg   <= '0;
            sub_cnt <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= data;
            sub_cnt <= '0;
            bit_cnt <= '0;
        end else if (run) begin
            if (sub_wrap) begin
                sub_cnt <= '0;
                shreg   <= {shreg[RESLINE_SIZE-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

    assign shift_bit = shreg[RESLINE_SIZE-1];
    assign last      = run && sub_wrap && (bit_cnt == BIT_LAST);

endmodule

// File: rtl/resolution_overlay.sv
// -----------------------------------------------------------------------------
// resolution_overlay
// Per-line sequencer for the resolution text overlay. On every line_start it
// decides whether the line falls in the overlay window, fetches the matching
// ROM row, arms on X_START and then emits the row with integer pixel scaling.
//   clock, reset : pixel clock, synchronous active-high reset
//   bus (slave)  : timing inputs, ROM port, overlay outputs, debug_state
// Parameters:
//   X_START     first active column of the window
//   Y_START     first active line of the window
//   SCALE_LOG2  log2 of the pixel/line repeat factor, 0..3
// Output timing: the pixel for counter_x = X_START + n appears one cycle later.
// -----------------------------------------------------------------------------
module resolution_overlay
    import resolution_overlay_pkg::*;
#(
    parameter int X_START    = 32,
    parameter int Y_START    = 16,
    parameter int SCALE_LOG2 = 1
) (
    input logic                clock,
    input logic                reset,
    resolution_overlay_if.slave bus
);

    localparam logic [COORD_W-1:0] X_START_C = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_START_C = COORD_W'(Y_START);

    OverlayState            state;
    logic [ROM_ROW_W-1:0]   rom_addr_q;
    logic                   px_q;
    logic                   active_q;

    logic [COORD_W:0]       dy;
    logic [COORD_W:0]       dy_scaled;
    logic                   line_in_window;
    logic [ROM_ROW_W-1:0]   row;

    logic                   arm_hit;
    logic                   sh_load;
    logic                   sh_run;
    logic                   sh_bit;
    logic                   sh_last;

    // Row index. dy carries an extra bit so lines above the window do not
    // alias onto valid rows; the explicit >= check keeps that unambiguous.
    always_comb begin
        dy             = line_offset(bus.counter_y, Y_START_C);
        dy_scaled      = dy >> SCALE_LOG2;
        line_in_window = (bus.counter_y >= Y_START_C) && (dy_scaled < 13'd16);
        row            = dy_scaled[ROM_ROW_W-1:0];
    end

    // The first pixel is emitted on the same edge that leaves ARMED, so the
    // shifter must already count that cycle. line_start always wins, which
    // also freezes the shifter on an abort edge.
    assign arm_hit = (state == ARMED) && (bus.counter_x == X_START_C);
    assign sh_load = !bus.line_start && (state == LOAD);
    assign sh_run  = !bus.line_start && (arm_hit || (state == SHIFT));

    resolution_overlay_shifter #(
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_shifter (
        .clock     (clock),
        .reset     (reset),
        .load      (sh_load),
        .data      (bus.rom_q),
        .run       (sh_run),
        .shift_bit (sh_bit),
        .last      (sh_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rom_addr_q <= '0;
            px_q       <= 1'b0;
            active_q   <= 1'b0;
        end else if (bus.line_start) begin
            // A new line restarts the sequence from any state, including a
            // line that is still being emitted.
            px_q     <= 1'b0;
            active_q <= 1'b0;
            if (bus.enable && line_in_window) begin
                state      <= FETCH;
                rom_addr_q <= row;
            end else begin
                state <= IDLE;
            end
        end else begin
            px_q     <= 1'b0;
            active_q <= 1'b0;
            case (state)
                FETCH: state <= LOAD;
                LOAD:  state <= ARMED;
                ARMED: begin
                    if (arm_hit) begin
                        state    <= SHIFT;
                        active_q <= 1'b1;
                        px_q     <= sh_bit;
                    end else if (bus.counter_x > X_START_C) begin
                        // Row arrived after the window start: skip this line.
                        state <= DONE;
                    end
                end
                SHIFT: begin
                    active_q <= 1'b1;
                    px_q     <= sh_bit;
                    if (sh_last) begin
                        state <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr       = rom_addr_q;
    assign bus.overlay_px     = px_q;
    assign bus.overlay_active = active_q;
    assign bus.debug_state    = state;

endmodule

// File: tb/tb_resolution_overlay.sv
// -----------------------------------------------------------------------------
// tb_resolution_overlay
// Three overlay instances share one timing stream:
//   u_main  X_START=32, Y_START=16, SCALE_LOG2=1
//   u_late  X_START=1,  Y_START=16, SCALE_LOG2=1
//   u_ns    X_START=32, Y_START=16, SCALE_LOG2=0
// Each has its own 1-cycle registered ROM model with identical contents.
// -----------------------------------------------------------------------------
module tb_resolution_overlay;
    import resolution_overlay_pkg::*;

    localparam int X_M = 32;
    localparam int S_M = 1;
    localparam int W_M = RESLINE_SIZE << S_M;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- shared stimulus ----------------
    logic               enable;
    logic               line_start;
    logic [COORD_W-1:0] counter_x;
    logic [COORD_W-1:0] counter_y;

    resolution_overlay_if bus_m ();
    resolution_overlay_if bus_l ();
    resolution_overlay_if bus_n ();

    assign bus_m.enable = enable;
    assign bus_m.line_start = line_start;
    assign bus_m.counter_x = counter_x;
    assign bus_m.counter_y = counter_y;
    assign bus_l.enable = enable;
    assign bus_l.line_start = line_start;
    assign bus_l.counter_x = counter_x;
    assign bus_l.counter_y = counter_y;
    assign bus_n.enable = enable;
    assign bus_n.line_start = line_start;
    assign bus_n.counter_x = counter_x;
    assign bus_n.counter_y = counter_y;

    // ---------------- ROM models ----------------
    logic [RESLINE_SIZE-1:0] rom_mem [16];

    always @(posedge clock) bus_m.rom_q <= rom_mem[bus_m.rom_addr];
    always @(posedge clock) bus_l.rom_q <= rom_mem[bus_l.rom_addr];
    always @(posedge clock) bus_n.rom_q <= rom_mem[bus_n.rom_addr];

    resolution_overlay #(.X_START(32), .Y_START(16), .SCALE_LOG2(1)) u_main (
        .clock(clock), .reset(reset), .bus(bus_m)
    );
    resolution_overlay #(.X_START(1), .Y_START(16), .SCALE_LOG2(1)) u_late (
        .clock(clock), .reset(reset), .bus(bus_l)
    );
    resolution_overlay #(.X_START(32), .Y_START(16), .SCALE_LOG2(0)) u_ns (
        .clock(clock), .reset(reset), .bus(bus_n)
    );

    // ---------------- scoreboard ----------------
    int tests;
    int fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs, let the DUT clock them, sample 1 time unit later.
    task automatic step(input logic ls, input logic [COORD_W-1:0] y,
                        input logic [COORD_W-1:0] x, input logic en, input logic rst);
        line_start = ls;
        counter_y  = y;
        counter_x  = x;
        enable     = en;
        reset      = rst;
        @(posedge clock);
        #1;
    endtask

    // One video line on u_main starting with line_start at counter_x = x0.
    // Every cycle is compared against the window rule: active for columns
    // X_M .. X_M+W_M-1 when the row was fetched in time, px = row bit
    // RESLINE_SIZE-1 - ((c-X_M) >> S_M).
    task automatic run_line(input logic [COORD_W-1:0] y, input logic [COORD_W-1:0] x0,
                            input logic en, input int ncyc, input logic fetch,
                            input logic [3:0] row,
                            output logic [3:0] addr0, output OverlayState st0,
                            output int act_cnt, output int bad_cnt,
                            output OverlayState st_end);
        logic [COORD_W-1:0] c;
        logic               exp_act;
        logic               exp_px;
        int                 n;
        act_cnt = 0;
        bad_cnt = 0;
        addr0   = '0;
        st0     = IDLE;
        for (int k = 0; k < ncyc; k++) begin
            c = x0 + COORD_W'(k);
            step(k == 0, y, c, en, 1'b0);
            if (k == 0) begin
                addr0 = bus_m.rom_addr;
                st0   = bus_m.debug_state;
            end
            exp_act = fetch && (int'(x0) + 3 <= X_M) && (k > 0)
                      && (int'(c) >= X_M) && (int'(c) < X_M + W_M);
            exp_px = 1'b0;
            if (exp_act) begin
                n      = int'(c) - X_M;
                exp_px = rom_mem[row][RESLINE_SIZE - 1 - (n >> S_M)];
            end
            if (bus_m.overlay_active) act_cnt++;
            if (bus_m.overlay_active !== exp_act || bus_m.overlay_px !== exp_px) bad_cnt++;
        end
        st_end = bus_m.debug_state;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x0;
        logic               en;
        int                 ncyc;
        logic               fetch;
        logic [3:0]         addr;
        OverlayState        st0;
        int                 act;
        OverlayState        st_end;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [3:0]  addr0;
        OverlayState st0;
        OverlayState st_end;
        int          act_cnt;
        int          bad_cnt;
        int          late_act;
        int          ns_act;
        int          ns_bad;
        int          ns_toggles;
        logic        ns_prev;
        logic        exp_a;
        logic        exp_p;

        tests = 0;
        fails = 0;

        // Row 0 alternates 1010... from the MSB; other rows are scrambled.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < RESLINE_SIZE; i++) begin
                if (r == 0) rom_mem[r][i] = (i % 2 == 1);
                else        rom_mem[r][i] = (((i * 5) + (r * 11)) % 7) < 3;
            end
        end

        //           y       x0     en    ncyc fetch addr   st0    act  st_end
        vecs[0] = '{12'd16,  12'd0,  1'b1, 320, 1'b1, 4'd0,  FETCH, 272, DONE};
        vecs[1] = '{12'd47,  12'd0,  1'b1, 320, 1'b1, 4'd15, FETCH, 272, DONE};
        vecs[2] = '{12'd48,  12'd0,  1'b1, 320, 1'b0, 4'd15, IDLE,  0,   IDLE};
        vecs[3] = '{12'd15,  12'd0,  1'b1, 320, 1'b0, 4'd15, IDLE,  0,   IDLE};
        vecs[4] = '{12'd20,  12'd0,  1'b0, 320, 1'b0, 4'd15, IDLE,  0,   IDLE};
        vecs[5] = '{12'd25,  12'd10, 1'b1, 320, 1'b1, 4'd4,  FETCH, 272, DONE};
        vecs[6] = '{12'd30,  12'd30, 1'b1, 320, 1'b1, 4'd7,  FETCH, 0,   DONE};
        vecs[7] = '{12'd17,  12'd29, 1'b1, 320, 1'b1, 4'd0,  FETCH, 272, DONE};
        vecs[8] = '{12'd46,  12'd0,  1'b1, 320, 1'b1, 4'd15, FETCH, 272, DONE};
        vecs[9] = '{12'd4095, 12'd0, 1'b1, 320, 1'b0, 4'd15, IDLE,  0,   IDLE};

        // ---------------- reset ----------------
        for (int k = 0; k < 3; k++) step(1'b0, 12'd0, 12'd0, 1'b1, 1'b1);
        step(1'b0, 12'd0, 12'd0, 1'b1, 1'b0);
        check("reset rom_addr", 32'(bus_m.rom_addr), 32'd0);
        check("reset active", 32'(bus_m.overlay_active), 32'd0);
        check("reset px", 32'(bus_m.overlay_px), 32'd0);
        check("reset state", 32'(bus_m.debug_state), 32'(IDLE));
        check("reset late active", 32'(bus_l.overlay_active), 32'd0);
        check("reset ns rom_addr", 32'(bus_n.rom_addr), 32'd0);

        // ---------------- table-driven lines ----------------
        for (int v = 0; v < 10; v++) begin
            run_line(vecs[v].y, vecs[v].x0, vecs[v].en, vecs[v].ncyc, vecs[v].fetch,
                     vecs[v].addr, addr0, st0, act_cnt, bad_cnt, st_end);
            check($sformatf("v%0d rom_addr", v), 32'(addr0), 32'(vecs[v].addr));
            check($sformatf("v%0d first state", v), 32'(st0), 32'(vecs[v].st0));
            check($sformatf("v%0d active cycles", v), 32'(act_cnt), 32'(vecs[v].act));
            check($sformatf("v%0d pixel errors", v), 32'(bad_cnt), 32'd0);
            check($sformatf("v%0d end state", v), 32'(st_end), 32'(vecs[v].st_end));
        end

        // ---------------- abort at bit 50 ----------------
        // Last driven column 132 = X_M + 100, i.e. bit index 50 at scale 2.
        run_line(12'd16, 12'd0, 1'b1, 133, 1'b1, 4'd0, addr0, st0, act_cnt, bad_cnt, st_end);
        check("abort pre active cycles", 32'(act_cnt), 32'd101);
        check("abort pre pixel errors", 32'(bad_cnt), 32'd0);
        check("abort pre state", 32'(st_end), 32'(SHIFT));
        check("abort pre px bit50", 32'(bus_m.overlay_px), 32'(rom_mem[0][RESLINE_SIZE-1-50]));
        run_line(12'd40, 12'd0, 1'b1, 320, 1'b1, 4'd12, addr0, st0, act_cnt, bad_cnt, st_end);
        check("abort new rom_addr", 32'(addr0), 32'd12);
        check("abort new state", 32'(st0), 32'(FETCH));
        check("abort new pixel errors", 32'(bad_cnt), 32'd0);
        check("abort new active cycles", 32'(act_cnt), 32'd272);

        // ---------------- reset mid-SHIFT (with a competing line_start) ----------------
        run_line(12'd16, 12'd0, 1'b1, 100, 1'b1, 4'd0, addr0, st0, act_cnt, bad_cnt, st_end);
        check("rst pre active cycles", 32'(act_cnt), 32'd68);
        check("rst pre state", 32'(st_end), 32'(SHIFT));
        step(1'b1, 12'd47, 12'd100, 1'b1, 1'b1);
        check("rst active", 32'(bus_m.overlay_active), 32'd0);
        check("rst px", 32'(bus_m.overlay_px), 32'd0);
        check("rst rom_addr", 32'(bus_m.rom_addr), 32'd0);
        check("rst state", 32'(bus_m.debug_state), 32'(IDLE));
        step(1'b0, 12'd0, 12'd101, 1'b1, 1'b0);
        check("rst idle active", 32'(bus_m.overlay_active), 32'd0);
        check("rst idle state", 32'(bus_m.debug_state), 32'(IDLE));
        run_line(12'd47, 12'd0, 1'b1, 320, 1'b1, 4'd15, addr0, st0, act_cnt, bad_cnt, st_end);
        check("post-rst rom_addr", 32'(addr0), 32'd15);
        check("post-rst active cycles", 32'(act_cnt), 32'd272);
        check("post-rst pixel errors", 32'(bad_cnt), 32'd0);

        // ---------------- late window start and no scaling ----------------
        // u_late (X_START=1) sees counter_x=3 when armed: window missed.
        // u_ns renders row 0 (1010...) unscaled over columns 32..167.
        late_act   = 0;
        ns_act     = 0;
        ns_bad     = 0;
        ns_toggles = 0;
        ns_prev    = 1'b0;
        for (int k = 0; k < 320; k++) begin
            step(k == 0, 12'd16, COORD_W'(k), 1'b1, 1'b0);
            if (bus_l.overlay_active) late_act++;
            exp_a = (k >= 32) && (k < 32 + RESLINE_SIZE);
            exp_p = exp_a && ((k - 32) % 2 == 0);
            if (bus_n.overlay_active) begin
                ns_act++;
                if (k > 32 && bus_n.overlay_px != ns_prev) ns_toggles++;
                ns_prev = bus_n.overlay_px;
            end
            if (bus_n.overlay_active !== exp_a || bus_n.overlay_px !== exp_p) ns_bad++;
        end
        check("late active cycles", 32'(late_act), 32'd0);
        check("late state", 32'(bus_l.debug_state), 32'(DONE));
        check("late rom_addr", 32'(bus_l.rom_addr), 32'd0);
        check("ns active cycles", 32'(ns_act), 32'd136);
        check("ns pixel errors", 32'(ns_bad), 32'd0);
        check("ns toggles", 32'(ns_toggles), 32'd135);
        check("ns state", 32'(bus_n.debug_state), 32'(DONE));

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
